// File: rtl/operand_multiple_table_pkg.sv
// Shared encodings for the Montgomery operand table.
// Select codes, fill FSM states and chunk-count helper.
package operand_table_pkg;

  typedef enum logic [2:0] {
    SEL_ZERO  = 3'b000,
    SEL_M     = 3'b001,
    SEL_2M    = 3'b010,
    SEL_3M    = 3'b011,
    SEL_B     = 3'b100,
    SEL_2B    = 3'b101,
    SEL_3B    = 3'b110,
    SEL_ZERO7 = 3'b111
  } sel_e;

  typedef enum logic [1:0] {
    IDLE,
    ADD_M,
    ADD_B,
    DONE
  } state_e;

  function automatic int nchunk(input int w, input int a);
    return (w + a - 1) / a;
  endfunction

endpackage

// File: rtl/operand_multiple_table_chunk_adder.sv
// One ADD_W-bit slice of the 3x fill adder.
// Purely combinational a + b + cin.
module chunk_adder #(
  parameter int ADD_W = 128
) (
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  input  logic             cin_i,
  output logic [ADD_W-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i}
                         + {{ADD_W{1'b0}}, cin_i};

endmodule

// File: rtl/operand_multiple_table.sv
// Self-filling {0,M,2M,3M,B,2B,3B} table for the Montgomery adder.
// 3M/3B are built chunk by chunk on one shared adder.
module operand_multiple_table
  import operand_table_pkg::*;
#(
  parameter int WIDTH = 1027,
  parameter int ADD_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] in_M,
  input  logic [WIDTH-1:0] in_B,
  output logic             table_valid,
  input  logic             sel_valid,
  input  logic [2:0]       select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             sel_err
);

  localparam int NCHUNK = nchunk(WIDTH, ADD_W);
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e           state_q;
  logic [CW-1:0]    chunk_q;
  logic             carry_q;
  logic [WIDTH-1:0] m_q, m2_q, m3_q;
  logic [WIDTH-1:0] b_q, b2_q, b3_q;
  logic             tv_q;
  logic [WIDTH-1:0] out_q;
  logic             ov_q;
  logic             err_q;

  logic             load_fire;
  logic             last_chunk;
  int               idx;
  logic [WIDTH-1:0] src_a, src_b, acc;
  logic [ADD_W-1:0] op_a, op_b, sum;
  logic             cout;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] entry;

  assign load_ready  = (state_q == IDLE) || (state_q == DONE);
  assign load_fire   = load_valid & load_ready;
  assign last_chunk  = (chunk_q == LAST);
  assign idx         = int'(chunk_q) * ADD_W;
  assign table_valid = tv_q;
  assign out_valid   = ov_q;
  assign out         = out_q;
  assign sel_err     = err_q;

  // Operand mux: the adder works on M/2M in ADD_M, B/2B otherwise.
  always_comb begin
    src_a = m_q;
    src_b = m2_q;
    acc   = m3_q;
    if (state_q == ADD_B) begin
      src_a = b_q;
      src_b = b2_q;
      acc   = b3_q;
    end
  end

  // Slice the current chunk out; bits past WIDTH read as zero.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < ADD_W; k++) begin
      if (idx + k < WIDTH) begin
        op_a[k] = src_a[idx+k];
        op_b[k] = src_b[idx+k];
      end
    end
  end

  chunk_adder #(.ADD_W(ADD_W)) u_add (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (carry_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Merge the new chunk sum back; sum bits past WIDTH are dropped.
  always_comb begin
    acc_d = acc;
    for (int k = 0; k < ADD_W; k++) begin
      if (idx + k < WIDTH) acc_d[idx+k] = sum[k];
    end
  end

  // Fill FSM: capture M/B, then chunked M+2M, then chunked B+2B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      chunk_q <= '0;
      carry_q <= 1'b0;
      m_q     <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      b_q     <= '0;
      b2_q    <= '0;
      b3_q    <= '0;
      tv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (load_fire) begin
            m_q     <= in_M;
            b_q     <= in_B;
            m2_q    <= in_M << 1;
            b2_q    <= in_B << 1;
            tv_q    <= 1'b0;
            chunk_q <= '0;
            carry_q <= 1'b0;
            state_q <= ADD_M;
          end
        end
        ADD_M: begin
          m3_q <= acc_d;
          if (last_chunk) begin
            chunk_q <= '0;
            carry_q <= 1'b0;
            state_q <= ADD_B;
          end else begin
            chunk_q <= chunk_q + 1'b1;
            carry_q <= cout;
          end
        end
        ADD_B: begin
          b3_q <= acc_d;
          if (last_chunk) begin
            chunk_q <= '0;
            carry_q <= 1'b0;
            tv_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            chunk_q <= chunk_q + 1'b1;
            carry_q <= cout;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Entry decode for the selection port.
  always_comb begin
    entry = '0;
    case (select)
      SEL_M:   entry = m_q;
      SEL_2M:  entry = m2_q;
      SEL_3M:  entry = m3_q;
      SEL_B:   entry = b_q;
      SEL_2B:  entry = b2_q;
      SEL_3B:  entry = b3_q;
      default: entry = '0;
    endcase
  end

  // Registered selection; requests before the table is ready flag an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      ov_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (sel_valid && tv_q) begin
      out_q <= entry;
      ov_q  <= 1'b1;
      err_q <= 1'b0;
    end else begin
      ov_q  <= 1'b0;
      err_q <= sel_valid;
    end
  end

endmodule
